da_shift_accumulator: RTL and testbench
=======================================

Name: da_shift_accumulator

Overview:
- Bit-serial distributed-arithmetic MAC for one DCT output row.
- Captures three signed input samples and walks their bit planes MSB-first.
- For each bit plane it drives a 3-bit address into the external coefficient ROM (one 8-entry DCT coefficient ROM per output).
- It shift-accumulates the returned signed coefficient sums into a full-precision result, then presents the result on a valid/ready output.

Parameters:
- DATA_W, 16: input sample width, signed two's complement.
- ROM_W, 16: significant ROM word width, signed Q2.14.
- ACC_W, 34: accumulator/output width (DATA_W+ROM_W+2).
- CNT_W, 4: bit-counter width (ceil(log2(DATA_W))).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input sample triple is valid.
- in_ready  out  1  block can accept a triple.
- x1  in  DATA_W  sample 1, signed; drives rom_addr[2].
- x2  in  DATA_W  sample 2, signed; drives rom_addr[1].
- x3  in  DATA_W  sample 3, signed; drives rom_addr[0].
- rom_cs  out  1  ROM chip select.
- rom_addr  out  3  ROM address = {x1[j], x2[j], x3[j]} of captured samples.
- rom_data  in  17  ROM word; bits [15:0] signed Q2.14; bit 16 ignored.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- y  out  ACC_W  signed result, scale 2^14 (Q.14).

Behaviour:
- Reset values (asynchronous on rst=1):
  - State = IDLE, bit counter = 0, sample registers = 0, accumulator = 0.
  - Outputs: in_ready=0 while rst=1, out_valid=0, y=0, rom_cs=0, rom_addr=0.
- Reset mid-operation aborts any computation with no output. After rst falls, in_ready=1 combinationally (state IDLE).
- The ROM reset pin is active-low. Integration drives it with ~rst.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge: capture x1/x2/x3, set j=DATA_W-1, go COMPUTE.
- COMPUTE:
  - rom_cs=1; rom_addr is combinational from the captured samples' bit j.
  - ROM is combinational: the rom_data sample R is valid in the same cycle.
  - At each edge:
    - If j=DATA_W-1: acc <= -sext(R) (MSB weight negative).
    - Else: acc <= (acc<<1) + sext(R).
    - j decrements.
  - After the edge with j=0, go DONE.
  - Exactly DATA_W COMPUTE cycles.
  - Arithmetic is exact: no rounding, truncation or saturation. Result y = sum over k of coef_k·x_k · 2^14, with coef_k from ROM.
- DONE:
  - out_valid=1, y = acc, held stable until out_ready=1 at an edge.
  - in_ready = out_ready (back-to-back allowed).
  - If out_ready&in_valid at the same edge: capture the new triple and go COMPUTE directly.
  - If out_ready only: go IDLE.
- Latency: accept edge to out_valid = DATA_W+1 edges (17 at default). Throughput 1 result per DATA_W+1 cycles with out_ready tied high.
- rom_cs=0 and rom_addr=0 in IDLE and DONE.
- in_valid in COMPUTE is ignored (in_ready=0); input samples may change freely.
- y holds its last value in IDLE; it updates only via acc.
- If in_valid arrives the same cycle rst falls, no capture occurs. The first capture is possible one edge after reset release, which guarantees the ROM's internal reset sync has released.

Test Plan:
- ROM model: addr 0..7 = 0, 11585, -11585, 0, -11585, 0, -23170, -11585, so y = 11585·(x3-x2-x1).
- x1=0, x2=0, x3=1, out_ready=1 -> out_valid exactly 17 cycles after the accept edge; y=11585; rom_cs high for 16 cycles.
- x1=-32768, x2=0, x3=0 -> y=379617280; then x1=32767, x2=32767, x3=-32768 -> y=-1138828670. Checks MSB negative weighting and full width.
- out_ready held 0 for 10 cycles after out_valid -> y stable, in_ready=0 before out_ready, exactly one result consumed.
- out_ready=1 and in_valid=1 with a new triple (0,0,100) at the DONE edge -> no IDLE cycle; next y=1158500 after 17 more edges.
- rst=1 asserted at COMPUTE j=7 -> out_valid=0, y=0, rom_cs=0 immediately; after release, a fresh (0,-5,3) yields y=92680 with no stale contribution.
- Random 500 triples against the reference model with random out_ready backpressure -> all results match and are in order.

Source files
------------

// File: rtl/da_shift_accumulator_if.sv
// rtl/da_shift_accumulator_if.sv - sample/result handshake and coefficient ROM bus for da_shift_accumulator
interface da_shift_accumulator_if #(
    parameter int DATA_W = 16,
    parameter int ROM_W  = 16,
    parameter int ACC_W  = 34
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] x3;
    logic              rom_cs;
    logic [2:0]        rom_addr;
    logic [ROM_W:0]    rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  y;

    modport slave (
        input  in_valid, x1, x2, x3, rom_data, out_ready,
        output in_ready, rom_cs, rom_addr, out_valid, y
    );

    modport master (
        output in_valid, x1, x2, x3, rom_data, out_ready,
        input  in_ready, rom_cs, rom_addr, out_valid, y
    );
endinterface

// File: rtl/da_shift_accumulator.sv
// rtl/da_shift_accumulator.sv - bit-serial distributed-arithmetic MAC for one DCT output row
module da_shift_accumulator #(
    parameter int DATA_W = 16,
    parameter int ROM_W  = 16,
    parameter int ACC_W  = 34,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic rst,
    da_shift_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_j;
    logic signed [DATA_W-1:0] r_x1;
    logic signed [DATA_W-1:0] r_x2;
    logic signed [DATA_W-1:0] r_x3;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_out_valid;

    logic signed [ROM_W-1:0]  w_rom_word;
    logic signed [ACC_W-1:0]  w_rom_sext;
    logic                     w_accept;
    logic                     w_unused_rom_msb;

    // Only the low ROM_W bits carry the coefficient sum; the top ROM bit is don't-care.
    assign w_rom_word       = bus.rom_data[ROM_W-1:0];
    assign w_unused_rom_msb = bus.rom_data[ROM_W];
    assign w_rom_sext       = {{(ACC_W-ROM_W){w_rom_word[ROM_W-1]}}, w_rom_word};

    assign bus.in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.rom_cs    = (r_state == COMPUTE);
    assign bus.rom_addr  = (r_state == COMPUTE) ? {r_x1[r_j], r_x2[r_j], r_x3[r_j]} : 3'b000;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_j         <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x1    <= bus.x1;
                        r_x2    <= bus.x2;
                        r_x3    <= bus.x3;
                        r_j     <= CNT_W'(DATA_W-1);
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // The sign-bit plane carries weight -2^(DATA_W-1), so it seeds the sum negated.
                    if (r_j == CNT_W'(DATA_W-1)) begin
                        r_acc <= -w_rom_sext;
                    end else begin
                        r_acc <= (r_acc <<< 1) + w_rom_sext;
                    end
                    if (r_j == '0) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_j <= r_j - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_x1    <= bus.x1;
                            r_x2    <= bus.x2;
                            r_x3    <= bus.x3;
                            r_j     <= CNT_W'(DATA_W-1);
                            r_state <= COMPUTE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_da_shift_accumulator.sv
// tb/tb_da_shift_accumulator.sv - self-checking bench for da_shift_accumulator
module tb_da_shift_accumulator;
    localparam int DATA_W = 16;
    localparam int ROM_W  = 16;
    localparam int ACC_W  = 34;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    da_shift_accumulator_if #(.DATA_W(DATA_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) bus ();

    da_shift_accumulator #(.DATA_W(DATA_W), .ROM_W(ROM_W), .ACC_W(ACC_W), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM; bit 16 is filled with junk that the design must ignore.
    function automatic logic [16:0] rom_fn(input logic [2:0] a);
        logic [15:0] w;
        case (a)
            3'd1: w = 16'sd11585;
            3'd2: w = -16'sd11585;
            3'd4: w = -16'sd11585;
            3'd6: w = -16'sd23170;
            3'd7: w = -16'sd11585;
            default: w = 16'sd0;
        endcase
        return {a[0] ^ a[2], w};
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_addr);

    function automatic longint model(input longint a, input longint b, input longint c);
        return 64'sd11585 * (c - b - a);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint y_val();
        return longint'($signed(bus.y));
    endfunction

    task automatic send(input longint a, input longint b, input longint c);
        int t;
        @(negedge clk);
        bus.x1 = a[15:0];
        bus.x2 = b[15:0];
        bus.x3 = c[15:0];
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_timeout", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input longint a, input longint b, input longint c,
                               output int edges, output int cs_cnt, output int addr_err);
        logic [2:0] ea;
        int plane;
        edges = 1;
        cs_cnt = 0;
        addr_err = 0;
        while (edges < 100) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (bus.rom_cs) begin
                plane = DATA_W - 1 - cs_cnt;
                ea = {a[plane], b[plane], c[plane]};
                if (bus.rom_addr !== ea) addr_err++;
                cs_cnt++;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    initial begin
        int edges, cs_cnt, aerr, bad;
        longint y0;
        int sent, got, cyc;
        bit acc_now;
        longint q[$];
        logic [15:0] r1, r2, r3;

        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x1 = '0;
        bus.x2 = '0;
        bus.x3 = '0;
        #2;
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_y", y_val(), 0);
        chk("rst_rom_cs", longint'(bus.rom_cs), 0);
        chk("rst_rom_addr", longint'(bus.rom_addr), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_in_ready", longint'(bus.in_ready), 1);

        // Latency and chip-select window
        bus.out_ready = 1'b1;
        send(0, 0, 1);
        wait_result(0, 0, 1, edges, cs_cnt, aerr);
        chk("lat_edges", edges, 17);
        chk("lat_rom_cs_cycles", cs_cnt, 16);
        chk("lat_addr_err", aerr, 0);
        chk("lat_out_valid", longint'(bus.out_valid), 1);
        chk("lat_y", y_val(), 11585);
        @(posedge clk);
        @(negedge clk);
        chk("consume_out_valid", longint'(bus.out_valid), 0);
        chk("consume_in_ready", longint'(bus.in_ready), 1);

        // Sign-bit weighting and full width
        send(-32768, 0, 0);
        wait_result(-32768, 0, 0, edges, cs_cnt, aerr);
        chk("msb_y", y_val(), 379617280);
        chk("msb_addr_err", aerr, 0);
        send(32767, 32767, -32768);
        wait_result(32767, 32767, -32768, edges, cs_cnt, aerr);
        chk("wide_y", y_val(), -64'sd1138828670);
        chk("wide_edges", edges, 17);

        // Output backpressure
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(0, -1, 0);
        wait_result(0, -1, 0, edges, cs_cnt, aerr);
        chk("bp_y", y_val(), 11585);
        y0 = y_val();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (y_val() !== y0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
        end
        chk("bp_hold_errors", bad, 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_one_consumed", longint'(bus.out_valid), 0);
        chk("bp_idle_in_ready", longint'(bus.in_ready), 1);

        // Back-to-back accept at the DONE edge
        send(0, 0, 5);
        wait_result(0, 0, 5, edges, cs_cnt, aerr);
        chk("b2b_first_y", y_val(), 57925);
        bus.x1 = 16'd0;
        bus.x2 = 16'd0;
        bus.x3 = 16'd100;
        bus.in_valid = 1'b1;
        #1 chk("b2b_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_result(0, 0, 100, edges, cs_cnt, aerr);
        chk("b2b_edges", edges, 17);
        chk("b2b_rom_cs_cycles", cs_cnt, 16);
        chk("b2b_y", y_val(), 1158500);

        // Reset mid-computation
        send(7, 8, 9);
        for (int k = 0; k < 9; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", longint'(bus.out_valid), 0);
        chk("abort_y", y_val(), 0);
        chk("abort_rom_cs", longint'(bus.rom_cs), 0);
        chk("abort_in_ready", longint'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        send(0, -5, 3);
        wait_result(0, -5, 3, edges, cs_cnt, aerr);
        chk("post_abort_y", y_val(), 92680);
        chk("post_abort_edges", edges, 17);

        // Random triples with random backpressure, in-order scoreboard
        sent = 0;
        got = 0;
        cyc = 0;
        bus.in_valid = 1'b0;
        while (got < 500 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!bus.in_valid && sent < 500 && $urandom_range(0, 3) != 0) begin
                r1 = 16'($urandom);
                r2 = 16'($urandom);
                r3 = 16'($urandom);
                bus.x1 = r1;
                bus.x2 = r2;
                bus.x3 = r3;
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc_now = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                chk("rand_queue_nonempty", longint'(q.size() != 0), 1);
                if (q.size() != 0) chk("rand_y", y_val(), q.pop_front());
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(longint'($signed(bus.x1)), longint'($signed(bus.x2)),
                                  longint'($signed(bus.x3))));
                sent++;
                acc_now = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc_now) bus.in_valid = 1'b0;
        end
        chk("rand_results", got, 500);
        bus.out_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
